// File: rtl/fft_pkg.sv
// Shared definitions for the FFT data-memory bank controllers.
package fft_pkg;

    localparam int NUM_BANKS  = 16;
    localparam int BANK_SEL_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } load_state_t;

endpackage

// File: rtl/fft_bank_skew.sv
// Maps a linear sample index to its skewed bank and in-bank word address.
// Row r is rotated by the digit sum of r so column-wise reads land on distinct banks.
module fft_bank_skew
    import fft_pkg::*;
#(
    parameter int LOG2N = 8,
    localparam int ROW_W = LOG2N - 4
) (
    input  logic [LOG2N-1:0]      idx,
    output logic [BANK_SEL_W-1:0] bank_sel,
    output logic [ROW_W-1:0]      bank_addr
);

    logic [7:0]            row_pad;
    logic [BANK_SEL_W-1:0] skew;

    // Rows are at most 6 bits wide, so two base-16 digits cover every legal frame size.
    assign row_pad   = 8'(idx[LOG2N-1:4]);
    assign skew      = row_pad[3:0] + row_pad[7:4];
    assign bank_sel  = idx[3:0] + skew;
    assign bank_addr = idx[LOG2N-1:4];

endmodule

// File: rtl/fft_bank_load_ctrl.sv
// Loads one N-point sample frame into the 16 FFT data banks through the bank demux.
// Holds the load FSM, the sample index counter and the registered demux outputs.
module fft_bank_load_ctrl
    import fft_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LOG2N  = 8,
    localparam int ROW_W = LOG2N - 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic [BANK_SEL_W-1:0] dmux_sel,
    output logic [DATA_W-1:0]     dmux_data,
    output logic                  wr_en,
    output logic [ROW_W-1:0]      bank_addr,
    output logic                  busy,
    output logic                  frame_done
);

    load_state_t           state_q;
    load_state_t           state_d;
    logic [LOG2N-1:0]      idx_q;
    logic                  accept;
    logic                  last_idx;
    logic [BANK_SEL_W-1:0] skew_sel;
    logic [ROW_W-1:0]      skew_addr;

    fft_bank_skew #(
        .LOG2N(LOG2N)
    ) u_skew (
        .idx      (idx_q),
        .bank_sel (skew_sel),
        .bank_addr(skew_addr)
    );

    assign last_idx = &idx_q;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == LOAD);

    // in_ready depends only on state and abort so an abort can block the final beat.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                in_ready = !abort;
                if (abort) begin
                    state_d = IDLE;
                end else if (in_valid && last_idx) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                idx_q <= '0;
            end else if (accept) begin
                idx_q <= idx_q + LOG2N'(1);
            end
        end
    end

    // Select, address and data hold between writes; only the strobes return to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            dmux_sel   <= '0;
            bank_addr  <= '0;
            dmux_data  <= '0;
        end else begin
            wr_en      <= accept;
            frame_done <= accept && last_idx;
            if (accept) begin
                dmux_sel  <= skew_sel;
                bank_addr <= skew_addr;
                dmux_data <= in_data;
            end
        end
    end

endmodule
